// File: rtl/fb_arbiter.sv
// Single-port framebuffer sequencer: VGA reads win, captured pixels drain via a small FIFO.
// Optional FB_CLEAR_EN macro adds a whole-frame clear engine (clr_start / clr_busy).
module fb_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int FB_W       = 160,
    parameter int FB_H       = 144,
    parameter int ADDR_W     = 15
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [7:0]        wr_x,
    input  logic [7:0]        wr_y,
    input  logic [1:0]        wr_data,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [1:0]        rd_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [1:0]        mem_wdata,
    input  logic [1:0]        mem_rdata,
    output logic [7:0]        drop_cnt
`ifdef FB_CLEAR_EN
    ,
    input  logic              clr_start,
    output logic              clr_busy
`endif
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);
    localparam logic [7:0] W8 = 8'(FB_W);
    localparam logic [7:0] H8 = 8'(FB_H);

    logic [ADDR_W-1:0] q_addr [FIFO_DEPTH];
    logic [1:0]        q_data [FIFO_DEPTH];
    logic [PW-1:0]     wp;
    logic [PW-1:0]     rp;
    logic [PW:0]       cnt;
    logic              full;
    logic              empty;
    logic              in_range;
    logic              accept;
    logic              push;
    logic              pop;
    logic              clr_act;
    logic [ADDR_W-1:0] clr_addr;
    logic [ADDR_W-1:0] pix_addr;
    logic              rd_s1;

    assign full     = (cnt == DEPTH_C);
    assign empty    = (cnt == '0);
    assign in_range = (wr_x < W8) && (wr_y < H8);
    assign accept   = wr_valid && wr_ready;
    assign push     = accept && in_range;
    assign pop      = !rd_req && !clr_act && !empty;
    assign rd_data  = mem_rdata;

    // y*160 + x built from shifts so no multiplier is inferred
    assign pix_addr = (ADDR_W'(wr_y) << 7) + (ADDR_W'(wr_y) << 5)
                    + ADDR_W'(wr_x);

`ifdef FB_CLEAR_EN
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FB_W * FB_H - 1);

    assign clr_act  = clr_busy;
    assign wr_ready = reset_n && !full && !clr_busy;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            clr_busy <= 1'b0;
            clr_addr <= '0;
        end else if (!clr_busy) begin
            if (clr_start) begin
                clr_busy <= 1'b1;
                clr_addr <= '0;
            end
        end else if (!rd_req) begin
            clr_addr <= clr_addr + 1'b1;
            if (clr_addr == LAST)
                clr_busy <= 1'b0;
        end
    end
`else
    assign clr_act  = 1'b0;
    assign clr_addr = '0;
    assign wr_ready = reset_n && !full;
`endif

    always_ff @(posedge vga_clk) begin
        if (push) begin
            q_addr[wp] <= pix_addr;
            q_data[wp] <= wr_data;
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push)
                wp <= wp + 1'b1;
            if (pop)
                rp <= rp + 1'b1;
            if (push && !pop)
                cnt <= cnt + 1'b1;
            else if (pop && !push)
                cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt <= '0;
        end else if (accept && !in_range && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
        end else if (rd_req) begin
            mem_addr <= rd_addr;
            mem_we   <= 1'b0;
        end else if (clr_act) begin
            mem_addr  <= clr_addr;
            mem_we    <= 1'b1;
            mem_wdata <= 2'd0;
        end else if (!empty) begin
            mem_addr  <= q_addr[rp];
            mem_we    <= 1'b1;
            mem_wdata <= q_data[rp];
        end else begin
            mem_we <= 1'b0;
        end
    end

    // RAM answers one cycle after mem_addr, so valid trails rd_req by two
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_s1    <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            rd_s1    <= rd_req;
            rd_valid <= rd_s1;
        end
    end
endmodule

// File: tb/tb_fb_arbiter.sv
// Randomized bench for fb_arbiter with a behavioural RAM and a reference model.
// Define FB_CLEAR_EN to also exercise the frame clear engine.
module tb_fb_arbiter;
    localparam int AW   = 15;
    localparam int NPIX = 160 * 144;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [7:0]    wr_x = '0;
    logic [7:0]    wr_y = '0;
    logic [1:0]    wr_data = '0;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_valid;
    logic [1:0]    rd_data;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [1:0]    mem_wdata;
    logic [1:0]    mem_rdata;
    logic [7:0]    drop_cnt;
`ifdef FB_CLEAR_EN
    logic          clr_start = 1'b0;
    logic          clr_busy;
`endif

    always #5 clk = ~clk;

    fb_arbiter dut (
        .vga_clk   (clk),
        .reset_n   (reset_n),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_x      (wr_x),
        .wr_y      (wr_y),
        .wr_data   (wr_data),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
`ifdef FB_CLEAR_EN
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
`endif
        .drop_cnt  (drop_cnt)
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic [1:0]    d;
    } wr_t;

    logic [1:0] ram [NPIX];
    bit         seen [NPIX];
    wr_t        wlog [$];
    wr_t        exp_q [$];
    int         shadow [int];
    int         drops = 0;
    int         checks = 0;
    int         failures = 0;

    function automatic logic [1:0] init_val(int a);
        return 2'(a ^ (a >> 2));
    endfunction

    function automatic logic [1:0] exp_rd(int a);
        return shadow.exists(a) ? 2'(shadow[a]) : init_val(a);
    endfunction

    // Synchronous-read RAM; unwritten words hold a fixed address pattern
    always @(posedge clk) begin
        if (mem_we && int'(mem_addr) < NPIX) begin
            ram[mem_addr]  <= mem_wdata;
            seen[mem_addr] <= 1'b1;
            wlog.push_back({mem_addr, mem_wdata});
        end
        if (int'(mem_addr) < NPIX && seen[mem_addr])
            mem_rdata <= ram[mem_addr];
        else
            mem_rdata <= init_val(int'(mem_addr));
    end

    function automatic void model_pix(int x, int y, int d);
        if (x < 160 && y < 144)
            exp_q.push_back({AW'(y * 160 + x), 2'(d)});
        else
            drops = (drops < 255) ? drops + 1 : 255;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        wr_valid = 1'b0;
        rd_req   = 1'b0;
`ifdef FB_CLEAR_EN
        clr_start = 1'b0;
`endif
    endtask

    task automatic do_reset();
        tick();
        reset_n = 1'b0;
        idle_inputs();
        repeat (2) tick();
        reset_n = 1'b1;
        wlog.delete();
        exp_q.delete();
        drops = 0;
        tick();
    endtask

    task automatic check_writes(string name);
        int n;
        for (int i = 0; i < 40 && wlog.size() < exp_q.size(); i++)
            tick();
        repeat (3) tick();
        checks++;
        if (wlog.size() != exp_q.size()) begin
            failures++;
            $display("FAIL %s write count got=%0d exp=%0d",
                     name, wlog.size(), exp_q.size());
        end
        n = (wlog.size() < exp_q.size()) ? wlog.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            if (wlog[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL %s write[%0d] got=%0d/%0d exp=%0d/%0d",
                         name, i, wlog[i].a, wlog[i].d,
                         exp_q[i].a, exp_q[i].d);
            end
        end
        foreach (exp_q[i])
            shadow[int'(exp_q[i].a)] = int'(exp_q[i].d);
        wlog.delete();
        exp_q.delete();
    endtask

    task automatic push_pix(int x, int y, int d);
        bit ok;
        ok = 1'b0;
        wr_valid = 1'b1;
        wr_x     = 8'(x);
        wr_y     = 8'(y);
        wr_data  = 2'(d);
        for (int i = 0; i < 50; i++) begin
            if (wr_ready) begin
                ok = 1'b1;
                model_pix(x, y, d);
                tick();
                break;
            end
            tick();
        end
        wr_valid = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL push_timeout got=0 exp=1");
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle_inputs();
        repeat (3) tick();
        checks += 6;
        if (wr_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_wr_ready got=%0b exp=0", wr_ready);
        end
        if (mem_we !== 1'b0) begin
            failures++;
            $display("FAIL rst_mem_we got=%0b exp=0", mem_we);
        end
        if (rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_rd_valid got=%0b exp=0", rd_valid);
        end
        if (mem_addr !== '0) begin
            failures++;
            $display("FAIL rst_mem_addr got=%0d exp=0", mem_addr);
        end
        if (mem_wdata !== 2'd0) begin
            failures++;
            $display("FAIL rst_mem_wdata got=%0d exp=0", mem_wdata);
        end
        if (drop_cnt !== 8'd0) begin
            failures++;
            $display("FAIL rst_drop_cnt got=%0d exp=0", drop_cnt);
        end
        reset_n = 1'b1;
        tick();
        checks++;
        if (wr_ready !== 1'b1) begin
            failures++;
            $display("FAIL post_rst_ready got=%0b exp=1", wr_ready);
        end
    endtask

    task automatic test_single_write();
        bit hit;
        int bad_rdy;
        hit = 1'b0;
        bad_rdy = 0;
        push_pix(3, 2, 2);
        for (int i = 0; i < 2 && !hit; i++) begin
            if (wr_ready !== 1'b1)
                bad_rdy++;
            if (mem_we === 1'b1) begin
                hit = 1'b1;
                checks += 2;
                if (mem_addr !== AW'(323)) begin
                    failures++;
                    $display("FAIL single_addr got=%0d exp=323", mem_addr);
                end
                if (mem_wdata !== 2'd2) begin
                    failures++;
                    $display("FAIL single_data got=%0d exp=2", mem_wdata);
                end
            end else begin
                tick();
            end
        end
        checks += 2;
        if (!hit) begin
            failures++;
            $display("FAIL single_we got=0 exp=1");
        end
        if (bad_rdy != 0) begin
            failures++;
            $display("FAIL single_ready got=%0d lows exp=0", bad_rdy);
        end
        check_writes("single");
    endtask

    task automatic test_reads();
        localparam int N = 24;
        bit         hv [N];
        int         ha [N];
        for (int k = 0; k < N + 2; k++) begin
            if (k >= 2) begin
                checks++;
                if (rd_valid !== hv[k-2]) begin
                    failures++;
                    $display("FAIL rd_valid[%0d] got=%0b exp=%0b",
                             k - 2, rd_valid, hv[k-2]);
                end
                if (hv[k-2]) begin
                    checks++;
                    if (rd_data !== exp_rd(ha[k-2])) begin
                        failures++;
                        $display("FAIL rd_data[%0d] addr=%0d got=%0d exp=%0d",
                                 k - 2, ha[k-2], rd_data, exp_rd(ha[k-2]));
                    end
                end
            end
            if (k < N) begin
                hv[k] = (k < 10) ? 1'b1 : 1'($urandom % 2);
                ha[k] = (k == 0) ? 100 : int'($urandom_range(0, NPIX - 1));
                rd_req  = hv[k];
                rd_addr = AW'(ha[k]);
            end else begin
                rd_req = 1'b0;
            end
            tick();
        end
    endtask

    task automatic test_starve();
        int px [5];
        int py [5];
        int pd [5];
        int idx;
        int nwe;
        idx = 0;
        nwe = 0;
        for (int i = 0; i < 5; i++) begin
            px[i] = $urandom_range(0, 159);
            py[i] = $urandom_range(0, 143);
            pd[i] = $urandom_range(0, 3);
        end
        rd_req  = 1'b1;
        rd_addr = AW'($urandom_range(0, NPIX - 1));
        for (int c = 0; c < 12; c++) begin
            if (mem_we === 1'b1)
                nwe++;
            wr_valid = (idx < 5);
            if (idx < 5) begin
                wr_x = 8'(px[idx]);
                wr_y = 8'(py[idx]);
                wr_data = 2'(pd[idx]);
            end
            if (wr_valid && wr_ready) begin
                model_pix(px[idx], py[idx], pd[idx]);
                idx++;
            end
            tick();
        end
        checks += 3;
        if (idx != 4) begin
            failures++;
            $display("FAIL starve_accepted got=%0d exp=4", idx);
        end
        if (wr_ready !== 1'b0) begin
            failures++;
            $display("FAIL starve_ready got=%0b exp=0", wr_ready);
        end
        if (nwe != 0) begin
            failures++;
            $display("FAIL starve_we got=%0d exp=0", nwe);
        end
        rd_req = 1'b0;
        for (int c = 0; c < 12 && idx < 5; c++) begin
            if (wr_ready) begin
                model_pix(px[idx], py[idx], pd[idx]);
                idx++;
            end
            tick();
        end
        wr_valid = 1'b0;
        checks++;
        if (idx != 5) begin
            failures++;
            $display("FAIL starve_fifth got=%0d exp=5", idx);
        end
        check_writes("starve");
    endtask

    task automatic test_drop();
        do_reset();
        push_pix(160, 0, 1);
        push_pix(0, 144, 2);
        check_writes("drop_edge");
        checks++;
        if (drop_cnt !== 8'(drops)) begin
            failures++;
            $display("FAIL drop_two got=%0d exp=%0d", drop_cnt, drops);
        end
        for (int i = 0; i < 300; i++) begin
            if ($urandom % 2)
                push_pix($urandom_range(160, 255), $urandom_range(0, 255), 1);
            else
                push_pix($urandom_range(0, 255), $urandom_range(144, 255), 1);
            if (i == 249) begin
                checks++;
                if (drop_cnt !== 8'(drops)) begin
                    failures++;
                    $display("FAIL drop_252 got=%0d exp=%0d", drop_cnt, drops);
                end
            end
        end
        tick();
        checks++;
        if (drop_cnt !== 8'(drops)) begin
            failures++;
            $display("FAIL drop_sat got=%0d exp=%0d", drop_cnt, drops);
        end
        check_writes("drop_bulk");
    endtask

    task automatic test_random();
        bit hv [$];
        int x;
        int y;
        int d;
        do_reset();
        for (int k = 0; k < 302; k++) begin
            if (k >= 2) begin
                checks++;
                if (rd_valid !== hv[k-2]) begin
                    failures++;
                    $display("FAIL rand_rd_valid[%0d] got=%0b exp=%0b",
                             k - 2, rd_valid, hv[k-2]);
                end
            end
            if (k < 300) begin
                rd_req  = ($urandom % 4 == 0);
                rd_addr = AW'($urandom_range(0, NPIX - 1));
                x = $urandom_range(0, 175);
                y = $urandom_range(0, 159);
                d = $urandom_range(0, 3);
                wr_valid = 1'($urandom % 2);
                wr_x = 8'(x);
                wr_y = 8'(y);
                wr_data = 2'(d);
                if (wr_valid && wr_ready)
                    model_pix(x, y, d);
            end else begin
                idle_inputs();
            end
            hv.push_back(rd_req);
            tick();
        end
        check_writes("random");
        checks++;
        if (drop_cnt !== 8'(drops)) begin
            failures++;
            $display("FAIL rand_drop got=%0d exp=%0d", drop_cnt, drops);
        end
    endtask

    task automatic test_reset_flush();
        int idx;
        int bad;
        idx = 0;
        bad = 0;
        do_reset();
        rd_req  = 1'b1;
        rd_addr = AW'(100);
        for (int c = 0; c < 6; c++) begin
            wr_valid = (idx < 3);
            wr_x = 8'($urandom_range(0, 159));
            wr_y = 8'($urandom_range(0, 143));
            wr_data = 2'($urandom_range(0, 3));
            if (wr_valid && wr_ready)
                idx++;
            tick();
        end
        wr_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        checks += 3;
        if (rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_rd_valid got=%0b exp=0", rd_valid);
        end
        if (mem_we !== 1'b0) begin
            failures++;
            $display("FAIL flush_we got=%0b exp=0", mem_we);
        end
        if (wr_ready !== 1'b0) begin
            failures++;
            $display("FAIL flush_ready got=%0b exp=0", wr_ready);
        end
        rd_req = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        wlog.delete();
        exp_q.delete();
        for (int c = 0; c < 10; c++) begin
            tick();
            if (rd_valid !== 1'b0 || mem_we !== 1'b0 || wr_ready !== 1'b1)
                bad++;
        end
        checks += 2;
        if (bad != 0) begin
            failures++;
            $display("FAIL flush_after got=%0d bad cycles exp=0", bad);
        end
        if (wlog.size() != 0) begin
            failures++;
            $display("FAIL flush_writes got=%0d exp=0", wlog.size());
        end
        wlog.delete();
    endtask

`ifdef FB_CLEAR_EN
    task automatic test_clear();
        int n;
        int bad_rdy;
        int bad_w;
        n = 0;
        bad_rdy = 0;
        bad_w = 0;
        do_reset();
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        checks++;
        if (clr_busy !== 1'b1) begin
            failures++;
            $display("FAIL clr_start got=%0b exp=1", clr_busy);
        end
        while (clr_busy === 1'b1 && n < 30000) begin
            if (wr_ready !== 1'b0)
                bad_rdy++;
            n++;
            tick();
        end
        tick();
        checks += 3;
        if (n != NPIX) begin
            failures++;
            $display("FAIL clr_cycles got=%0d exp=%0d", n, NPIX);
        end
        if (bad_rdy != 0) begin
            failures++;
            $display("FAIL clr_ready got=%0d exp=0", bad_rdy);
        end
        if (wlog.size() != NPIX) begin
            failures++;
            $display("FAIL clr_writes got=%0d exp=%0d", wlog.size(), NPIX);
        end
        foreach (wlog[i])
            if (wlog[i] !== {AW'(i), 2'd0})
                bad_w++;
        checks++;
        if (bad_w != 0) begin
            failures++;
            $display("FAIL clr_content got=%0d bad exp=0", bad_w);
        end
        for (int a = 0; a < NPIX; a++)
            shadow[a] = 0;
        wlog.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_single_write();
        test_reads();
        test_starve();
        test_drop();
        test_random();
        test_reset_flush();
`ifdef FB_CLEAR_EN
        test_clear();
        test_reads();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
